// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
// Request fields are held stable by the master from the first request cycle through done.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            func3;
    logic [DATA_W-1:0]     rd_data;
    logic                  done;
    logic                  busy;
    logic                  err;

    modport master (
        output MemRead, MemWrite, addr, wr_data, func3,
        input  rd_data, done, busy, err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wr_data, func3,
        output rd_data, done, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: programmable wait states, byte/half/word little-endian access,
// sign/zero-extended loads, one-cycle done pulse with error flag.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic [7:0] mem [2**DM_ADDRESS];

    logic                  req, is_store, func3_ok, misaligned, req_err, wr_en;
    logic [1:0]            size;
    logic [DM_ADDRESS-1:0] a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic [DATA_W-1:0]     load_ext;

    // MemWrite wins over MemRead when both are asserted.
    assign req      = bus.MemRead | bus.MemWrite;
    assign is_store = bus.MemWrite;
    assign size     = bus.func3[1:0];

    assign func3_ok = is_store ? (bus.func3 inside {3'b000, 3'b001, 3'b010})
                               : (bus.func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = ((size == 2'b01) && bus.addr[0]) ||
                        ((size == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign req_err    = !func3_ok || misaligned;

    assign a1 = bus.addr + DM_ADDRESS'(1);
    assign a2 = bus.addr + DM_ADDRESS'(2);
    assign a3 = bus.addr + DM_ADDRESS'(3);
    assign b0 = mem[bus.addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        load_ext = '0;
        case (bus.func3)
            3'b000:  load_ext = {{24{b0[7]}}, b0};
            3'b001:  load_ext = {{16{b1[7]}}, b1, b0};
            3'b010:  load_ext = {b3, b2, b1, b0};
            3'b100:  load_ext = {24'd0, b0};
            3'b101:  load_ext = {16'd0, b1, b0};
            default: load_ext = '0;
        endcase
    end

    // Reset gates the write so an ACCESS cut short by reset never commits.
    assign wr_en = (state_q == S_ACCESS) && is_store && !reset;

    // NOTE: the byte array has no reset; clearing it would force a flop-based memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.addr] <= bus.wr_data[7:0];
            if (size != 2'b00) begin
                mem[a1] <= bus.wr_data[15:8];
            end
            if (size == 2'b10) begin
                mem[a2] <= bus.wr_data[23:16];
                mem[a3] <= bus.wr_data[31:24];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // NOTE: every next-state value is defaulted first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_err) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end else begin
                        err_d = 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_d = S_ACCESS;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!is_store) begin
                    rd_d = load_ext;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = bus.done & err_q;
    assign bus.rd_data = rd_q;
    assign bus.busy    = req & !bus.done;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the datapath's MEM-stage load/store port. It accepts one request at a time from the core's `MemRead`/`MemWrite`/`addr`/`wr_data`/`func3` signals and inserts a programmable number of wait states. It performs byte/half/word accesses on a byte-addressed little-endian array and returns sign- or zero-extended load data with a one-cycle `done` pulse. While a request is in flight it drives `busy` so the pipeline can hold the MEM stage.

## Interface

Parameters:
- `DM_ADDRESS`, 9: byte-address width. The array holds 2^DM_ADDRESS bytes.
- `DATA_W`, 32: data width. Only 32 is supported.
- `WAIT_CYCLES`, 2: wait states inserted before the array access. Legal range is 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request. Wins if asserted together with `MemRead`.
- `addr` input DM_ADDRESS: byte address.
- `wr_data` input DATA_W: store data, with the low bytes used for SB/SH.
- `func3` input 3: access size and sign, RISC-V encoding.
- `rd_data` output DATA_W: extended load data, held until the next completing load or error.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: combinational; equals (`MemRead`|`MemWrite`) & !`done`.
- `err` output 1: high with `done` when the request was misaligned or had an illegal `func3`.

## Operation

- Requester protocol:
  - The requester holds `MemRead`, `MemWrite`, `addr`, `wr_data` and `func3` stable from the first request cycle through the `done` cycle.
  - A request still asserted in the cycle after `done` is a new request.
- States are IDLE, WAIT, ACCESS and DONE. A 4-bit counter `cnt` supports WAIT.
- IDLE transitions:
  - No request: stay in IDLE.
  - Request with error: go to DONE and latch the error.
  - Legal request with `WAIT_CYCLES`=0: go to ACCESS.
  - Legal request otherwise: go to WAIT and load `cnt`=`WAIT_CYCLES`-1.
- WAIT: if `cnt`==0, go to ACCESS; otherwise decrement `cnt`.
- ACCESS:
  - Stores commit the selected bytes at the clock edge ending ACCESS.
  - Loads register the extended data into `rd_data` at the same edge.
  - ACCESS then goes to DONE.
- DONE: `done`=1, `err` is the latched value, next state is IDLE.
- Error conditions:
  - `func3` not in {000,001,010} for a store, or not in {000,001,010,100,101} for a load.
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`!=0.
- On error: no array write occurs and `rd_data` is set to 0.
- Load extension, little-endian:
  - LB (000): byte sign-extended.
  - LH (001): halfword sign-extended.
  - LW (010): full word.
  - LBU (100): byte zero-extended.
  - LHU (101): halfword zero-extended.
- Stores: SB writes byte `addr`, SH writes bytes `addr` and `addr+1`, SW writes 4 bytes. All other bytes are unchanged.
- Stores do not modify `rd_data`.
- The array is not cleared by reset.

## Timing

- The request is first visible in cycle 0.
- Legal access: ACCESS is in cycle `WAIT_CYCLES`+1, and `done` is in cycle `WAIT_CYCLES`+2. With `WAIT_CYCLES`=2, `done` is in cycle 4.
- Error access: `done`=`err`=1 in cycle 1.
- `busy` is 1 from cycle 0 through the cycle before `done` and is 0 in the `done` cycle.
- Back-to-back: the minimum spacing between `done` pulses is `WAIT_CYCLES`+3 cycles for legal requests.
- Reset values: state IDLE, `cnt`=0, `rd_data`=0, `done`=0, `err`=0. `busy` follows its combinational equation.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending store is aborted, including a reset asserted during ACCESS before the edge. No `done` is produced for the aborted request.
- Requests presented while `reset` is high are ignored. A request held through reset deassertion is accepted starting with the first edge after release.

## Test plan

- SW `wr_data`=0xDEADBEEF to `addr`=0x010, then LW from 0x010, with `WAIT_CYCLES`=2 -> `done` in cycle 4 of each request, `rd_data`=0xDEADBEEF, `err`=0.
- SB 0x80 to 0x013, then LB 0x013 -> `rd_data`=0xFFFFFF80; LBU 0x013 -> 0x00000080; LW 0x010 -> 0x80ADBEEF.
- SH 0x1234 to 0x003 (misaligned) -> `done`=`err`=1 in cycle 1 and `rd_data`=0; a following LW 0x000 shows the word unchanged.
- Load with `func3`=011 -> `err`=1 in cycle 1. `MemRead`=`MemWrite`=1 with SW 0x5 to 0x020 -> a store is performed and `rd_data` is unchanged.
- SW 0xAAAAAAAA to 0x030, with `reset` pulsed during the WAIT state -> no `done`, `busy` behaves per its equation, `rd_data`=0; a subsequent LW 0x030 returns the prior contents.
- `WAIT_CYCLES`=0: four back-to-back LW requests -> `done` every 3 cycles, `busy`=0 only in the `done` cycles.
